// File: rtl/hamming_merge.sv
// hamming_merge: merges two ascending word streams into one ascending stream.
// Equal heads are emitted once, so both copies are consumed.
// Ports: clock/clear (synchronous, active-high).
//   aReq/aAck/aValue and bReq/bAck/bValue are pull channels from upstream FIFOs.
//   outReq/outAck/outValue is the push channel to the downstream FIFO.
//   Every channel uses a one-cycle request pulse answered by a one-cycle acknowledge pulse.
module hamming_merge #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [WORD_SIZE-1:0] aValue,
  output logic                 aReq,
  input  logic                 aAck,
  input  logic [WORD_SIZE-1:0] bValue,
  output logic                 bReq,
  input  logic                 bAck,
  output logic [WORD_SIZE-1:0] outValue,
  output logic                 outReq,
  input  logic                 outAck
);

  typedef enum logic [1:0] {FETCH, WAIT_HEADS, PUSH, WAIT_PUSH} state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] head_a, head_b;
  logic                 valid_a, valid_b;
  logic                 pend_a, pend_b, pend_out;
  logic                 cons_a, cons_b;

  // An acknowledge only counts while its request is outstanding.
  logic                 take_a, take_b;
  logic [WORD_SIZE-1:0] nxt_head_a, nxt_head_b;
  logic                 nxt_valid_a, nxt_valid_b;
  logic                 a_lt_b, b_lt_a;

  // The comparison looks at the heads as they will be after this edge.
  // That lets the edge which captures the last head also register the output.
  // Result: outReq appears in the cycle right after the final acknowledge.
  always_comb begin
    take_a      = pend_a & aAck;
    take_b      = pend_b & bAck;
    nxt_head_a  = take_a ? aValue : head_a;
    nxt_head_b  = take_b ? bValue : head_b;
    nxt_valid_a = valid_a | take_a;
    nxt_valid_b = valid_b | take_b;
    a_lt_b      = nxt_head_a < nxt_head_b;
    b_lt_a      = nxt_head_b < nxt_head_a;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= FETCH;
      head_a   <= '0;
      head_b   <= '0;
      valid_a  <= 1'b0;
      valid_b  <= 1'b0;
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
      pend_out <= 1'b0;
      cons_a   <= 1'b0;
      cons_b   <= 1'b0;
      aReq     <= 1'b0;
      bReq     <= 1'b0;
      outReq   <= 1'b0;
      outValue <= '0;
    end else begin
      // Requests are single-cycle pulses unless re-asserted below.
      aReq   <= 1'b0;
      bReq   <= 1'b0;
      outReq <= 1'b0;
      case (state)
        FETCH: begin
          if (!valid_a && !pend_a) begin
            aReq   <= 1'b1;
            pend_a <= 1'b1;
          end
          if (!valid_b && !pend_b) begin
            bReq   <= 1'b1;
            pend_b <= 1'b1;
          end
          state <= WAIT_HEADS;
        end

        WAIT_HEADS: begin
          head_a  <= nxt_head_a;
          head_b  <= nxt_head_b;
          valid_a <= nxt_valid_a;
          valid_b <= nxt_valid_b;
          if (take_a) pend_a <= 1'b0;
          if (take_b) pend_b <= 1'b0;
          if (nxt_valid_a && nxt_valid_b) begin
            // The smaller head wins; on a tie both heads are consumed.
            outValue <= b_lt_a ? nxt_head_b : nxt_head_a;
            cons_a   <= !b_lt_a;
            cons_b   <= !a_lt_b;
            outReq   <= 1'b1;
            pend_out <= 1'b1;
            state    <= PUSH;
          end
        end

        // This is the outReq cycle. An acknowledge can only arrive from the next cycle on.
        PUSH: state <= WAIT_PUSH;

        WAIT_PUSH: begin
          if (outAck) begin
            pend_out <= 1'b0;
            // Consumed heads are released and refetched on the same edge.
            // The fetch then lands one cycle after outAck.
            // The unconsumed head keeps its value and valid flag.
            if (cons_a) begin
              valid_a <= 1'b0;
              aReq    <= 1'b1;
              pend_a  <= 1'b1;
            end
            if (cons_b) begin
              valid_b <= 1'b0;
              bReq    <= 1'b1;
              pend_b  <= 1'b1;
            end
            state <= WAIT_HEADS;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule
